// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// muldiv_sequencer_if : EX-stage request / HI-LO result bundle for the MUL/DIV unit
// Rev 1.0
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [5:0]      func;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] mf_data;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output valid, func, rs_val, rt_val, flush,
    input  stall, busy, done, mf_data, hi, lo
  );

  modport slave (
    input  valid, func, rs_val, rt_val, flush,
    output stall, busy, done, mf_data, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// muldiv_sequencer : iterative shift-add multiplier / restoring divider owning HI/LO
// Rev 1.0
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv_sequencer_if.slave     bus
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;

  logic            w_is_muldiv, w_is_mfmt, w_known, w_signed;
  logic            w_rs_neg, w_rt_neg;
  logic [XLEN-1:0] w_rs_mag, w_rt_mag;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_div_hi, w_div_lo, w_mul_hi, w_mul_lo;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quot, w_rem;

  assign w_is_muldiv = (bus.func[5:2] == 4'b0110);
  assign w_is_mfmt   = (bus.func[5:2] == 4'b0100);
  assign w_known     = w_is_muldiv | w_is_mfmt;
  assign w_signed    = ~bus.func[0];
  assign w_rs_neg    = w_signed & bus.rs_val[XLEN-1];
  assign w_rt_neg    = w_signed & bus.rt_val[XLEN-1];
  assign w_rs_mag    = w_rs_neg ? -bus.rs_val : bus.rs_val;
  assign w_rt_mag    = w_rt_neg ? -bus.rt_val : bus.rt_val;

  // Multiply: acc_hi = running upper half, acc_lo = multiplier shifting out / product low bits
  assign w_mul_sum = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opnd_q}) : {1'b0, acc_hi_q};
  assign w_mul_hi  = w_mul_sum[XLEN:1];
  assign w_mul_lo  = {w_mul_sum[0], acc_lo_q[XLEN-1:1]};

  // Divide: acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in
  assign w_rem_sh = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, opnd_q});
  assign w_div_hi = w_ge ? (w_rem_sh[XLEN-1:0] - opnd_q) : w_rem_sh[XLEN-1:0];
  assign w_div_lo = {acc_lo_q[XLEN-2:0], w_ge};

  assign w_prod     = {acc_hi_q, acc_lo_q};
  assign w_prod_fix = neg_res_q ? -w_prod : w_prod;
  assign w_quot     = dz_q ? {XLEN{1'b1}} : (neg_res_q ? -acc_lo_q : acc_lo_q);
  assign w_rem      = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.valid && w_is_muldiv && !bus.flush) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = bus.func[1];
          neg_res_d = w_rs_neg ^ w_rt_neg;
          neg_rem_d = w_rs_neg;
          dz_d      = bus.func[1] && (bus.rt_val == '0);
          acc_hi_d  = '0;
          acc_lo_d  = bus.func[1] ? w_rs_mag : w_rt_mag;
          opnd_d    = bus.func[1] ? w_rt_mag : w_rs_mag;
        end else if (bus.valid && w_is_mfmt && bus.func[0]) begin
          if (bus.func[1]) lo_d = bus.rs_val;
          else             hi_d = bus.rs_val;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = is_div_q ? w_div_hi : w_mul_hi;
          acc_lo_d = is_div_q ? w_div_lo : w_mul_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = S_FIX;
            done_d  = 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          if (is_div_q) begin
            hi_d = w_rem;
            lo_d = w_quot;
          end else begin
            {hi_d, lo_d} = w_prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign bus.stall   = bus.valid && w_known && (state_q != S_IDLE);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = (bus.valid && w_is_mfmt && !bus.func[0]) ? (bus.func[1] ? lo_q : hi_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer : directed + random checks of the MUL/DIV sequencer against an arithmetic model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MIPS HI/LO semantics computed with plain 64-bit arithmetic
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0; l = '0;
    case (f)
      F_MULT:  begin p = sa * sb; {h, l} = p; end
      F_MULTU: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
      F_DIV:   if (b == 0) begin l = '1; h = a; end
               else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      default: if (b == 0) begin l = '1; h = a; end
               else begin l = a / b; h = a % b; end
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit trail);
    logic [31:0] eh, el;
    int k, nstall;
    bit seen;
    model(f, a, b, eh, el);
    bus.valid = 1'b1; bus.func = f; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk); #1;
    if (trail) bus.func = F_MFHI; else bus.valid = 1'b0;
    #1;
    chk("busy_after_accept", bus.busy, 1);
    k = 1; seen = 0; nstall = 0;
    while (k <= 40 && !seen) begin
      if (bus.stall) nstall++;
      if (bus.done) seen = 1;
      else begin step(); k++; end
    end
    chk("done_latency", k, 33);
    chk("busy_in_fix", bus.busy, 1);
    if (trail) chk("stall_cycles", nstall, 33);
    step();
    chk("hi", bus.hi, eh);
    chk("lo", bus.lo, el);
    chk("done_after", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    if (trail) begin
      chk("stall_released", bus.stall, 0);
      chk("mfhi_after_op", bus.mf_data, eh);
    end
    bus.valid = 1'b0;
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    bus.valid = 1'b0; bus.func = '0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_mf", bus.mf_data, 0);
    @(posedge clk); #1; rst_n = 1'b1; #1;

    run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run_op(F_MULT, -32'sd7, 32'd3, 1'b0);
    run_op(F_DIV, -32'sd7, 32'd2, 1'b0);
    run_op(F_DIVU, 32'd100, 32'd7, 1'b1);
    run_op(F_DIV, 32'd5, 32'd0, 1'b0);
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(F_DIV, 32'hFFFFFFF0, 32'd0, 1'b0);

    // MTHI then MFHI on the next cycle
    bus.valid = 1'b1; bus.func = F_MTHI; bus.rs_val = 32'h1234; #1;
    chk("mthi_stall", bus.stall, 0);
    step(); bus.func = F_MFHI; #1;
    chk("mfhi_data", bus.mf_data, 32'h1234);
    chk("mfhi_stall", bus.stall, 0);
    m_hi = 32'h1234;
    step(); bus.valid = 1'b0;

    // flush at iteration 10, then a DIVU the following cycle
    bus.valid = 1'b1; bus.func = F_MULT; bus.rs_val = 32'd1234567; bus.rt_val = -32'sd99;
    @(posedge clk); #1; bus.valid = 1'b0; #1;
    repeat (10) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_hi", bus.hi, m_hi);
    chk("flush_lo", bus.lo, m_lo);
    run_op(F_DIVU, 32'hDEADBEEF, 32'd12345, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rf = {4'b0110, 2'($urandom_range(0, 3))};
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(rf, ra, rb, 1'($urandom_range(0, 1)));
    end

    // reset at iteration 20 abandons the operation
    bus.valid = 1'b1; bus.func = F_MULTU; bus.rs_val = 32'hCAFEF00D; bus.rt_val = 32'h1234;
    @(posedge clk); #1; bus.valid = 1'b0; #1;
    repeat (20) step();
    rst_n = 1'b0;
    step();
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    rst_n = 1'b1;
    step();
    bus.valid = 1'b1; bus.func = F_MFLO; #1;
    chk("mflo_after_rst", bus.mf_data, 0);
    chk("mflo_stall", bus.stall, 0);
    step(); bus.valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
